// File: rtl/hwpe_ctrl_uloop_pkg.sv
// hwpe_ctrl_uloop_package: default sizing, control bundle and FSM states for the micro-loop sequencer
package hwpe_ctrl_uloop_package;

    localparam int ULOOP_NB_LOOPS  = 6;
    localparam int ULOOP_CNT_WIDTH = 12;
    localparam int ULOOP_NB_REG    = 4;
    localparam int ULOOP_NB_RO_REG = 28;
    localparam int ULOOP_REG_WIDTH = 32;
    localparam int ULOOP_LENGTH    = 16;
    localparam int ULOOP_ACCUM_W   = 8;

    typedef struct packed {
        logic                     clear;
        logic                     start;
        logic [ULOOP_ACCUM_W-1:0] accum_loop;
    } ctrl_uloop_t;

    typedef enum logic [1:0] {UL_IDLE, UL_EMIT, UL_UPDATE, UL_DONE} uloop_state_t;

endpackage

// File: rtl/hwpe_ctrl_uloop_nest.sv
// hwpe_ctrl_uloop_nest: finds the lowest non-exhausted loop level and the index vector after stepping it
module hwpe_ctrl_uloop_nest #(
    parameter int NB_LOOPS  = 6,
    parameter int CNT_WIDTH = 12,
    localparam int LW = $clog2(NB_LOOPS)
) (
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] idx_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
    output logic [LW-1:0]                 lvl_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_next_o,
    output logic                          all_last_o
);

    logic                 found;
    logic [CNT_WIDTH-1:0] rng;
    logic [CNT_WIDTH-1:0] cur;

    // levels below the stepped one are exhausted and wrap to 0; a zero range behaves as one iteration
    always_comb begin
        found      = 1'b0;
        lvl_o      = '0;
        idx_next_o = idx_i;
        rng        = '0;
        cur        = '0;
        for (int k = 0; k < NB_LOOPS; k++) begin
            rng = range_i[k*CNT_WIDTH +: CNT_WIDTH];
            cur = idx_i[k*CNT_WIDTH +: CNT_WIDTH];
            if (!found) begin
                if (cur == ((rng == '0) ? '0 : rng - 1'b1)) begin
                    idx_next_o[k*CNT_WIDTH +: CNT_WIDTH] = '0;
                end else begin
                    found                                = 1'b1;
                    lvl_o                                = LW'(k);
                    idx_next_o[k*CNT_WIDTH +: CNT_WIDTH] = cur + 1'b1;
                end
            end
        end
        all_last_o = !found;
    end

endmodule

// File: rtl/hwpe_ctrl_uloop_gen.sv
// hwpe_ctrl_uloop_gen: micro-coded nested-loop sequencer emitting register offsets over valid/ready
module hwpe_ctrl_uloop_gen
    import hwpe_ctrl_uloop_package::*;
#(
    parameter int NB_LOOPS  = ULOOP_NB_LOOPS,
    parameter int CNT_WIDTH = ULOOP_CNT_WIDTH,
    parameter int NB_REG    = ULOOP_NB_REG,
    parameter int NB_RO_REG = ULOOP_NB_RO_REG,
    parameter int REG_WIDTH = ULOOP_REG_WIDTH,
    parameter int LENGTH    = ULOOP_LENGTH,
    localparam int LW  = $clog2(NB_LOOPS),
    localparam int AW  = $clog2(LENGTH),
    localparam int NW  = $clog2(LENGTH+1),
    localparam int OPW = $clog2(NB_REG > NB_RO_REG ? NB_REG : NB_RO_REG),
    localparam int CW  = 1 + 2*OPW
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [LW-1:0]                 accum_loop_i,
    input  logic [NB_LOOPS*AW-1:0]        loops_addr_i,
    input  logic [NB_LOOPS*NW-1:0]        loops_nbops_i,
    input  logic [LENGTH*CW-1:0]          code_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0] ro_reg_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [NB_REG*REG_WIDTH-1:0]   offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o,
    output logic                          accum_o,
    output logic                          busy_o,
    output logic                          done_o
);

    uloop_state_t                  state_q, state_d;
    logic [NB_REG*REG_WIDTH-1:0]   regs_q, regs_d;
    logic [NB_LOOPS*CNT_WIDTH-1:0] idx_q, idx_d, idx_next;
    logic [AW-1:0]                 ptr_q, ptr_d;
    logic [NW-1:0]                 cnt_q, cnt_d;
    logic [LW-1:0]                 lvl;
    logic                          all_last;
    ctrl_uloop_t                   ctrl;
    logic                          op_sel;
    logic [OPW-1:0]                op_a, op_b;
    logic                          op_ok;
    logic [REG_WIDTH-1:0]          operand;
    logic [AW-1:0]                 lvl_addr;
    logic [NW-1:0]                 lvl_nbops;

    assign ctrl = '{clear: clear_i, start: start_i, accum_loop: ULOOP_ACCUM_W'(accum_loop_i)};
    assign {op_sel, op_a, op_b} = code_i[int'(ptr_q)*CW +: CW];
    assign lvl_addr  = loops_addr_i[int'(lvl)*AW +: AW];
    assign lvl_nbops = loops_nbops_i[int'(lvl)*NW +: NW];

    hwpe_ctrl_uloop_nest #(
        .NB_LOOPS  (NB_LOOPS),
        .CNT_WIDTH (CNT_WIDTH)
    ) i_nest (
        .idx_i      (idx_q),
        .range_i    (range_i),
        .lvl_o      (lvl),
        .idx_next_o (idx_next),
        .all_last_o (all_last)
    );

    // operand fetch; an out-of-range index on either side turns the op into a no-op
    always_comb begin
        operand = '0;
        op_ok   = int'(op_a) < NB_REG && (op_sel ? int'(op_b) < NB_RO_REG : int'(op_b) < NB_REG);
        if (op_ok)
            operand = op_sel ? ro_reg_i[int'(op_b)*REG_WIDTH +: REG_WIDTH] : regs_q[int'(op_b)*REG_WIDTH +: REG_WIDTH];
    end

    // sequencer next state: emit, step the nest on handshake, run that level's ops; clear overrides all
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            UL_IDLE: if (ctrl.start) begin
                regs_d  = '0;
                idx_d   = '0;
                state_d = UL_EMIT;
            end
            UL_EMIT: if (ready_i) begin
                if (all_last) begin
                    state_d = UL_DONE;
                end else begin
                    idx_d   = idx_next;
                    ptr_d   = lvl_addr;
                    cnt_d   = lvl_nbops;
                    state_d = (lvl_nbops == '0) ? UL_EMIT : UL_UPDATE;
                end
            end
            UL_UPDATE: begin
                if (op_ok)
                    regs_d[int'(op_a)*REG_WIDTH +: REG_WIDTH] = regs_q[int'(op_a)*REG_WIDTH +: REG_WIDTH] + operand;
                ptr_d   = (ptr_q == AW'(LENGTH-1)) ? '0 : ptr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q <= NW'(1)) ? UL_EMIT : UL_UPDATE;
            end
            default: state_d = UL_IDLE;
        endcase
        if (ctrl.clear) begin
            state_d = UL_IDLE;
            regs_d  = '0;
            idx_d   = '0;
            ptr_d   = '0;
            cnt_d   = '0;
        end
    end

    // state, register file, loop indices and op sequencing registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= UL_IDLE;
            regs_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // accum flag: any index within the accumulation nest has moved past its first iteration
    always_comb begin
        accum_o = 1'b0;
        for (int k = 0; k < NB_LOOPS; k++)
            if (k <= int'(ctrl.accum_loop) && idx_q[k*CNT_WIDTH +: CNT_WIDTH] != '0)
                accum_o = 1'b1;
    end

    assign valid_o = state_q == UL_EMIT;
    assign busy_o  = state_q != UL_IDLE;
    assign done_o  = state_q == UL_DONE;
    assign offs_o  = regs_q;
    assign idx_o   = idx_q;

endmodule

// File: tb/tb_hwpe_ctrl_uloop_gen.sv
// tb_hwpe_ctrl_uloop_gen: directed self-checking bench for the micro-loop sequencer
module tb_hwpe_ctrl_uloop_gen;

    localparam int NL = 2, CWD = 12, NR = 4, NRO = 28, RW = 32, LEN = 16, OC = 11;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0, ready_i = 1'b1;
    logic [0:0]          accum_loop_i = '0;
    logic [NL*4-1:0]     loops_addr_i = '0;
    logic [NL*5-1:0]     loops_nbops_i = '0;
    logic [LEN*OC-1:0]   code_i = '0;
    logic [NL*CWD-1:0]   range_i = '0;
    logic [NRO*RW-1:0]   ro_reg_i = '0;
    logic                valid_o, accum_o, busy_o, done_o;
    logic [NR*RW-1:0]    offs_o;
    logic [NL*CWD-1:0]   idx_o;
    int                  checks = 0, errors = 0;
    logic [31:0]         e_i0[6], e_i1[6], e_r0[6], e_r1[6], e_r2[6], e_acc[6], e_lat[6];

    hwpe_ctrl_uloop_gen #(
        .NB_LOOPS(NL), .CNT_WIDTH(CWD), .NB_REG(NR), .NB_RO_REG(NRO), .REG_WIDTH(RW), .LENGTH(LEN)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .accum_loop_i(accum_loop_i),
        .loops_addr_i(loops_addr_i), .loops_nbops_i(loops_nbops_i), .code_i(code_i), .range_i(range_i),
        .ro_reg_i(ro_reg_i), .ready_i(ready_i), .valid_o(valid_o), .offs_o(offs_o), .idx_o(idx_o),
        .accum_o(accum_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic sel, input logic [4:0] a, input logic [4:0] b);
        code_i[i*OC +: OC] = {sel, a, b};
    endtask

    task automatic next_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o && n < 50);
        check("valid_wait", valid_o, 1);
    endtask

    task automatic cfg1();
        code_i        = '0;
        ro_reg_i      = '0;
        range_i       = {12'd2, 12'd3};
        loops_addr_i  = {4'd1, 4'd0};
        loops_nbops_i = {5'd2, 5'd1};
        accum_loop_i  = 1'b0;
        set_op(0, 1'b1, 5'd0, 5'd0);
        set_op(1, 1'b1, 5'd0, 5'd1);
        set_op(2, 1'b1, 5'd1, 5'd2);
        ro_reg_i[31:0]  = 32'd4;
        ro_reg_i[63:32] = 32'd10;
        ro_reg_i[95:64] = 32'd1;
        e_i0  = '{0, 1, 2, 0, 1, 2};
        e_i1  = '{0, 0, 0, 1, 1, 1};
        e_r0  = '{0, 4, 8, 18, 22, 26};
        e_r1  = '{0, 0, 0, 1, 1, 1};
        e_r2  = '{0, 0, 0, 0, 0, 0};
        e_acc = '{0, 1, 1, 0, 1, 1};
        e_lat = '{0, 2, 2, 3, 2, 2};
    endtask

    task automatic run(input int n, input int stall_at);
        int lat;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_valid", valid_o, 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                next_valid(lat);
                check("latency", lat, e_lat[i]);
            end
            check("idx0", idx_o[11:0], e_i0[i]);
            check("idx1", idx_o[23:12], e_i1[i]);
            check("r0", offs_o[31:0], e_r0[i]);
            check("r1", offs_o[63:32], e_r1[i]);
            check("r2", offs_o[95:64], e_r2[i]);
            check("accum", accum_o, e_acc[i]);
            if (i == stall_at) begin
                ready_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", valid_o, 1);
                    check("stall_r0", offs_o[31:0], e_r0[i]);
                    check("stall_idx0", idx_o[11:0], e_i0[i]);
                end
                ready_i = 1'b1;
            end
        end
        @(negedge clk);
        check("done_pulse", done_o, 1);
        check("done_valid", valid_o, 0);
        @(negedge clk);
        check("done_clear", done_o, 0);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        int lat;
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_offs", offs_o, 0);
        check("rst_done", done_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        // nominal two-level walk
        cfg1();
        run(6, -1);
        // backpressure at the third offset
        run(6, 2);
        // all ranges zero: one offset only
        range_i = '0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("z_valid", valid_o, 1);
        check("z_offs", offs_o, 0);
        check("z_idx", idx_o, 0);
        @(negedge clk);
        check("z_done", done_o, 1);
        check("z_no_second", valid_o, 0);
        @(negedge clk);
        check("z_idle", busy_o, 0);
        // clear during UPDATE
        cfg1();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("c_valid", valid_o, 1);
        @(negedge clk);
        check("c_in_update", valid_o, 0);
        check("c_busy", busy_o, 1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("c_busy_after", busy_o, 0);
        check("c_valid_after", valid_o, 0);
        check("c_offs", offs_o, 0);
        check("c_idx", idx_o, 0);
        repeat (3) begin
            @(negedge clk);
            check("c_no_done", done_o, 0);
        end
        // asynchronous reset while holding an offset
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        next_valid(lat);
        next_valid(lat);
        ready_i = 1'b0;
        check("a_pre_r0", offs_o[31:0], 8);
        #1 rst_i = 1'b1;
        #1;
        check("a_valid", valid_o, 0);
        check("a_offs", offs_o, 0);
        check("a_busy", busy_o, 0);
        @(negedge clk);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        // modulo wrap, op pointer wrap, no-op indices, reg-reg source
        code_i        = '0;
        ro_reg_i      = '0;
        ro_reg_i[31:0]   = 32'hFFFF_FFFF;
        ro_reg_i[127:96] = 32'd1;
        range_i       = {12'd2, 12'd2};
        loops_addr_i  = {4'd1, 4'd15};
        loops_nbops_i = {5'd4, 5'd2};
        accum_loop_i  = 1'b1;
        set_op(15, 1'b1, 5'd0, 5'd0);
        set_op(0, 1'b1, 5'd0, 5'd3);
        set_op(1, 1'b1, 5'd1, 5'd0);
        set_op(2, 1'b1, 5'd5, 5'd0);
        set_op(3, 1'b1, 5'd1, 5'd30);
        set_op(4, 1'b0, 5'd2, 5'd1);
        e_i0  = '{0, 1, 0, 1, 0, 0};
        e_i1  = '{0, 0, 1, 1, 0, 0};
        e_r0  = '{0, 0, 0, 0, 0, 0};
        e_r1  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        e_r2  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0};
        e_acc = '{0, 1, 1, 1, 0, 0};
        e_lat = '{0, 3, 5, 3, 0, 0};
        run(4, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
